// File: rtl/assoc_cache_controller_if.sv
// rtl/assoc_cache_controller_if.sv - CPU data port and block memory port of the cache controller
interface assoc_cache_controller_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 8,
    parameter int OFF_W  = 2,
    parameter int CNT_W  = 16
);
    localparam int BLK_W = WORD_W << OFF_W;

    logic                    read;
    logic                    write;
    logic [ADDR_W-1:0]       address;
    logic [WORD_W-1:0]       writedata;
    logic [WORD_W-1:0]       readdata;
    logic                    busywait;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_W-OFF_W-1:0] mem_address;
    logic [BLK_W-1:0]        mem_writedata;
    logic [BLK_W-1:0]        mem_readdata;
    logic                    mem_busywait;
    logic [CNT_W-1:0]        hit_count;
    logic [CNT_W-1:0]        miss_count;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata,
               hit_count, miss_count
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata,
               hit_count, miss_count
    );
endinterface

// File: rtl/assoc_cache_controller.sv
// rtl/assoc_cache_controller.sv - N-way set-associative write-back cache controller with per-set LRU
module assoc_cache_controller #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 8,
    parameter int OFF_W  = 2,
    parameter int IDX_W  = 3,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    assoc_cache_controller_if.slave bus
);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = WORD_W << OFF_W;
    localparam int SETS  = 1 << IDX_W;
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [BLK_W-1:0]  data_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [AGE_W-1:0]  age_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [AGE_W-1:0]  victim_q, victim_d;
    logic [BLK_W-1:0]  fill_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              access, hit, lookup_hit, miss_start, wr_hit;
    logic [AGE_W-1:0]  hit_way, lru_way, lru_age, touch_way, touch_age;
    logic              touch_en;
    logic [BLK_W-1:0]  hit_blk;

    assign req_tag    = bus.address[ADDR_W-1 -: TAG_W];
    assign req_idx    = bus.address[OFF_W +: IDX_W];
    assign req_off    = bus.address[OFF_W-1:0];
    // read and write together is treated as no request at all
    assign access     = bus.read ^ bus.write;
    assign lookup_hit = (state_q == IDLE) && access && hit;
    assign miss_start = (state_q == IDLE) && access && !hit;
    assign wr_hit     = lookup_hit && bus.write;
    assign hit_blk    = data_q[req_idx][hit_way];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // Invalid ways are filled lowest-first; otherwise evict the oldest way.
    always_comb begin
        lru_way = '0;
        lru_age = age_q[req_idx][0];
        for (int w = 1; w < WAYS; w++) begin
            if (age_q[req_idx][w] > lru_age) begin
                lru_age = age_q[req_idx][w];
                lru_way = AGE_W'(w);
            end
        end
        victim_d = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim_d = AGE_W'(w);
        end
    end

    assign touch_en  = lookup_hit || (state_q == UPDATE);
    assign touch_way = (state_q == UPDATE) ? victim_q : hit_way;
    assign touch_age = age_q[req_idx][touch_way];

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (miss_start)
                    state_d = (valid_q[req_idx][victim_d] && dirty_q[req_idx][victim_d])
                              ? WRITEBACK : FETCH;
            end
            WRITEBACK: if (!bus.mem_busywait) state_d = FETCH;
            FETCH:     if (!bus.mem_busywait) state_d = UPDATE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busywait      = 1'b1;
        bus.readdata      = '0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writedata = '0;
        case (state_q)
            IDLE: begin
                bus.busywait = access && !hit;
                if (lookup_hit && bus.read)
                    bus.readdata = hit_blk[req_off*WORD_W +: WORD_W];
            end
            WRITEBACK: begin
                bus.mem_write     = 1'b1;
                bus.mem_address   = {tag_q[req_idx][victim_q], req_idx};
                bus.mem_writedata = data_q[req_idx][victim_q];
            end
            FETCH: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = {req_tag, req_idx};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
            victim_q   <= '0;
            fill_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_hit && (hit_cnt_q != {CNT_W{1'b1}}))
                hit_cnt_q <= hit_cnt_q + 1'b1;
            if (miss_start) begin
                victim_q <= victim_d;
                if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
            if (wr_hit) dirty_q[req_idx][hit_way] <= 1'b1;
            if ((state_q == FETCH) && !bus.mem_busywait) fill_q <= bus.mem_readdata;
            if (state_q == UPDATE) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == touch_way)
                        age_q[req_idx][w] <= '0;
                    else if (age_q[req_idx][w] < touch_age)
                        age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                end
            end
        end
    end

    // Block and tag storage carries no reset; valid bits gate every use.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == UPDATE) begin
                data_q[req_idx][victim_q] <= fill_q;
                tag_q[req_idx][victim_q]  <= req_tag;
            end else if (wr_hit) begin
                data_q[req_idx][hit_way][req_off*WORD_W +: WORD_W] <= bus.writedata;
            end
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_assoc_cache_controller.sv
// tb/tb_assoc_cache_controller.sv - directed self-checking bench for assoc_cache_controller
module tb_assoc_cache_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    assoc_cache_controller_if ifc ();
    assoc_cache_controller dut (.clock(clock), .reset(reset), .bus(ifc));

    always #5 clock = ~clock;

    // memory: busy for two cycles of a request, done on the third
    logic [1:0] mem_cnt = 2'd0;
    always @(posedge clock) begin
        if (reset || !(ifc.mem_read || ifc.mem_write) || (mem_cnt == 2'd2)) mem_cnt <= 2'd0;
        else mem_cnt <= mem_cnt + 2'd1;
    end
    assign ifc.mem_busywait = (mem_cnt != 2'd2);
    assign ifc.mem_readdata = {ifc.mem_address, 2'd3, ifc.mem_address, 2'd2,
                               ifc.mem_address, 2'd1, ifc.mem_address, 2'd0};

    int          rd_done = 0, wb_done = 0, req_cycles = 0, both_seen = 0;
    logic [5:0]  last_rd_addr = '0, last_wb_addr = '0;
    logic [31:0] last_wb_data = '0;
    always @(posedge clock) begin
        if (ifc.mem_read || ifc.mem_write) req_cycles <= req_cycles + 1;
        if (ifc.mem_read && ifc.mem_write) both_seen <= both_seen + 1;
        if (ifc.mem_write && !ifc.mem_busywait) begin
            wb_done      <= wb_done + 1;
            last_wb_addr <= ifc.mem_address;
            last_wb_data <= ifc.mem_writedata;
        end
        if (ifc.mem_read && !ifc.mem_busywait) begin
            rd_done      <= rd_done + 1;
            last_rd_addr <= ifc.mem_address;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        ifc.read = 1'b0; ifc.write = 1'b0; ifc.address = '0; ifc.writedata = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, output logic [7:0] rdat, output int cyc);
        ifc.read = rd; ifc.write = wr; ifc.address = a; ifc.writedata = wd;
        cyc = 0;
        @(negedge clock);
        while (ifc.busywait && cyc < 50) begin @(negedge clock); cyc++; end
        checks++;
        if (cyc >= 50) begin failures++; $display("FAIL access_timeout addr=%h got busywait stuck, expected release", a); end
        rdat = ifc.readdata;
        @(posedge clock);
        #1 ifc.read = 1'b0; ifc.write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++; if (ifc.busywait !== 1'b0) begin failures++; $display("FAIL reset_busywait got %b expected 0", ifc.busywait); end
        checks++; if (ifc.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got %b expected 0", ifc.mem_read); end
        checks++; if (ifc.mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got %b expected 0", ifc.mem_write); end
        checks++; if (ifc.readdata !== 8'h00) begin failures++; $display("FAIL reset_readdata got %h expected 00", ifc.readdata); end
        checks++; if (ifc.hit_count !== 16'd0) begin failures++; $display("FAIL reset_hit_count got %0d expected 0", ifc.hit_count); end
        checks++; if (ifc.miss_count !== 16'd0) begin failures++; $display("FAIL reset_miss_count got %0d expected 0", ifc.miss_count); end
    endtask

    task automatic test_read_miss();
        int cyc;
        logic [7:0] rdat;
        do_reset();
        ifc.read = 1'b1; ifc.address = 8'h00;
        @(negedge clock);
        checks++; if (ifc.busywait !== 1'b1) begin failures++; $display("FAIL miss_busywait got %b expected 1", ifc.busywait); end
        @(negedge clock);
        checks++; if (ifc.mem_read !== 1'b1) begin failures++; $display("FAIL fetch_mem_read got %b expected 1", ifc.mem_read); end
        checks++; if (ifc.mem_address !== 6'h00) begin failures++; $display("FAIL fetch_mem_address got %h expected 00", ifc.mem_address); end
        cyc = 0;
        while (ifc.busywait && cyc < 50) begin @(negedge clock); cyc++; end
        checks++; if (cyc >= 50) begin failures++; $display("FAIL miss_timeout got %0d cycles expected <50", cyc); end
        checks++; if (ifc.readdata !== 8'h00) begin failures++; $display("FAIL miss_readdata got %h expected 00", ifc.readdata); end
        @(posedge clock);
        #1 ifc.read = 1'b0;
        checks++; if (ifc.miss_count !== 16'd1) begin failures++; $display("FAIL miss_count1 got %0d expected 1", ifc.miss_count); end
        checks++; if (ifc.hit_count !== 16'd1) begin failures++; $display("FAIL hit_count1 got %0d expected 1", ifc.hit_count); end
        access(1'b1, 1'b0, 8'h03, 8'h00, rdat, cyc);
        checks++; if (rdat !== 8'h03) begin failures++; $display("FAIL hit_offset3 got %h expected 03", rdat); end
        checks++; if (cyc !== 0) begin failures++; $display("FAIL hit_no_stall got %0d expected 0", cyc); end
        checks++; if (ifc.hit_count !== 16'd2) begin failures++; $display("FAIL hit_count2 got %0d expected 2", ifc.hit_count); end
    endtask

    task automatic test_write_allocate();
        int cyc, rc;
        logic [7:0] rdat;
        do_reset();
        access(1'b0, 1'b1, 8'h05, 8'hAA, rdat, cyc);
        checks++; if (cyc == 0) begin failures++; $display("FAIL wr_miss_stall got %0d expected >0", cyc); end
        rc = req_cycles;
        access(1'b1, 1'b0, 8'h05, 8'h00, rdat, cyc);
        checks++; if (rdat !== 8'hAA) begin failures++; $display("FAIL wr_readback got %h expected aa", rdat); end
        checks++; if (req_cycles !== rc) begin failures++; $display("FAIL wr_hit_no_mem got %0d expected %0d", req_cycles, rc); end
        access(1'b1, 1'b0, 8'h04, 8'h00, rdat, cyc);
        checks++; if (rdat !== 8'h04) begin failures++; $display("FAIL wr_fill_neighbour got %h expected 04", rdat); end
    endtask

    task automatic test_two_way();
        int cyc;
        logic [7:0] rdat;
        do_reset();
        access(1'b1, 1'b0, 8'h00, 8'h00, rdat, cyc);
        access(1'b1, 1'b0, 8'h20, 8'h00, rdat, cyc);
        checks++; if (rdat !== 8'h20) begin failures++; $display("FAIL way1_fill got %h expected 20", rdat); end
        access(1'b1, 1'b0, 8'h00, 8'h00, rdat, cyc);
        checks++; if (cyc !== 0) begin failures++; $display("FAIL way0_resident got %0d expected 0", cyc); end
        checks++; if (ifc.miss_count !== 16'd2) begin failures++; $display("FAIL two_way_miss got %0d expected 2", ifc.miss_count); end
        checks++; if (ifc.hit_count !== 16'd3) begin failures++; $display("FAIL two_way_hit got %0d expected 3", ifc.hit_count); end
    endtask

    task automatic test_writeback();
        int cyc, wb0;
        logic [7:0] rdat;
        do_reset();
        access(1'b0, 1'b1, 8'h00, 8'h11, rdat, cyc);
        access(1'b1, 1'b0, 8'h20, 8'h00, rdat, cyc);
        wb0 = wb_done;
        access(1'b1, 1'b0, 8'h40, 8'h00, rdat, cyc);
        checks++; if (rdat !== 8'h40) begin failures++; $display("FAIL evict_fill got %h expected 40", rdat); end
        checks++; if (wb_done !== wb0 + 1) begin failures++; $display("FAIL wb_count got %0d expected %0d", wb_done, wb0 + 1); end
        checks++; if (last_wb_addr !== 6'h00) begin failures++; $display("FAIL wb_address got %h expected 00", last_wb_addr); end
        checks++; if (last_wb_data !== 32'h03020111) begin failures++; $display("FAIL wb_data got %h expected 03020111", last_wb_data); end
        checks++; if (last_rd_addr !== 6'h10) begin failures++; $display("FAIL evict_fetch_addr got %h expected 10", last_rd_addr); end
        access(1'b1, 1'b0, 8'h20, 8'h00, rdat, cyc);
        checks++; if (cyc !== 0 || rdat !== 8'h20) begin failures++; $display("FAIL mru_kept got cyc=%0d data=%h expected cyc=0 data=20", cyc, rdat); end
        checks++; if (ifc.miss_count !== 16'd3) begin failures++; $display("FAIL wb_miss_count got %0d expected 3", ifc.miss_count); end
    endtask

    task automatic test_read_write_conflict();
        int cyc, rc;
        logic [7:0] rdat;
        do_reset();
        access(1'b1, 1'b0, 8'h00, 8'h00, rdat, cyc);
        rc = req_cycles;
        ifc.read = 1'b1; ifc.write = 1'b1; ifc.address = 8'h08; ifc.writedata = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if (ifc.busywait !== 1'b0) begin failures++; $display("FAIL conflict_busywait got %b expected 0", ifc.busywait); end
        end
        @(posedge clock);
        #1 ifc.read = 1'b0; ifc.write = 1'b0;
        checks++; if (ifc.hit_count !== 16'd1 || ifc.miss_count !== 16'd1) begin failures++; $display("FAIL conflict_counters got hit=%0d miss=%0d expected 1 1", ifc.hit_count, ifc.miss_count); end
        checks++; if (req_cycles !== rc) begin failures++; $display("FAIL conflict_no_mem got %0d expected %0d", req_cycles, rc); end
        access(1'b1, 1'b0, 8'h08, 8'h00, rdat, cyc);
        checks++; if (cyc == 0 || rdat !== 8'h08) begin failures++; $display("FAIL conflict_not_allocated got cyc=%0d data=%h expected miss data=08", cyc, rdat); end
    endtask

    task automatic test_reset_in_fetch();
        int cyc;
        logic [7:0] rdat;
        do_reset();
        ifc.read = 1'b1; ifc.address = 8'h00;
        cyc = 0;
        @(negedge clock);
        while (!ifc.mem_read && cyc < 20) begin @(negedge clock); cyc++; end
        checks++; if (ifc.mem_read !== 1'b1) begin failures++; $display("FAIL reach_fetch got %b expected 1", ifc.mem_read); end
        @(posedge clock);
        #1 reset = 1'b1; ifc.read = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++; if (ifc.mem_read !== 1'b0) begin failures++; $display("FAIL abort_mem_read got %b expected 0", ifc.mem_read); end
        checks++; if (ifc.busywait !== 1'b0) begin failures++; $display("FAIL abort_busywait got %b expected 0", ifc.busywait); end
        @(posedge clock);
        #1 reset = 1'b0;
        access(1'b1, 1'b0, 8'h00, 8'h00, rdat, cyc);
        checks++; if (cyc == 0) begin failures++; $display("FAIL after_abort_miss got %0d expected >0", cyc); end
        checks++; if (ifc.miss_count !== 16'd1) begin failures++; $display("FAIL after_abort_count got %0d expected 1", ifc.miss_count); end
    endtask

    initial begin
        ifc.read = 1'b0; ifc.write = 1'b0; ifc.address = '0; ifc.writedata = '0;
        test_reset();
        test_read_miss();
        test_write_allocate();
        test_two_way();
        test_writeback();
        test_read_write_conflict();
        test_reset_in_fetch();
        checks++; if (both_seen !== 0) begin failures++; $display("FAIL mem_rw_exclusive got %0d cycles expected 0", both_seen); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
